// File: rtl/map9_job_sequencer_if.sv
// map9_job_sequencer_if -- bundled stream and core signals for map9_job_sequencer.
//
// Carries the operand input stream (in_valid/in_data/in_ready), the core
// issue/return signals (core_N/core_start, core_done/core_dp/core_sr), the
// result output stream (out_valid/out_ready/out_dp/out_sr/out_err) and the
// status outputs (busy, fifo_count).
//   slave  : the sequencer's view (drives in_ready, core_*, out_*, status)
//   master : the environment's view (drives operands, core returns, out_ready)
// DEPTH must match the sequencer's DEPTH so fifo_count widths agree.
interface map9_job_sequencer_if #(
   parameter int unsigned DEPTH = 4
);
   logic                    in_valid;
   logic [8:0]              in_data;
   logic                    in_ready;
   logic [8:0]              core_N;
   logic                    core_start;
   logic                    core_done;
   logic [8:0]              core_dp;
   logic [7:0]              core_sr;
   logic                    out_valid;
   logic                    out_ready;
   logic [8:0]              out_dp;
   logic [7:0]              out_sr;
   logic                    out_err;
   logic                    busy;
   logic [$clog2(DEPTH):0]  fifo_count;

   modport slave (
      input  in_valid, in_data, core_done, core_dp, core_sr, out_ready,
      output in_ready, core_N, core_start, out_valid, out_dp, out_sr, out_err,
             busy, fifo_count
   );

   modport master (
      output in_valid, in_data, core_done, core_dp, core_sr, out_ready,
      input  in_ready, core_N, core_start, out_valid, out_dp, out_sr, out_err,
             busy, fifo_count
   );
endinterface

// File: rtl/map9_job_sequencer.sv
// map9_job_sequencer -- job front-end for the map9v3 core.
//
// Operands arrive on a valid/ready stream into a DEPTH-entry FIFO. The FSM
// pops one at a time into core_N with a one-cycle core_start pulse, skips any
// stale done left by the previous job, waits for done, then captures
// core_dp/core_sr into a result register offered on a valid/ready stream.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - map9_job_sequencer_if.slave: in_*, core_*, out_*, busy, fifo_count
//
// Parameters:
//   DEPTH   - FIFO depth, power of two >= 2
//   TIMEOUT - per-job watchdog limit in wait cycles
//
// Optional feature: define MAP9_SEQ_TIMEOUT_EN to build the watchdog. Without
// it no counter exists, out_err is tied 0 and the FSM may wait indefinitely.
module map9_job_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                      clock,
   input  logic                      reset,
   map9_job_sequencer_if.slave       bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("map9_job_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_CLR,
      S_WAIT_DONE
   } state_t;

   state_t          state;

   // FIFO storage and pointers
   logic [8:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            in_ready;
   logic            push;
   logic            pop;

   // registered outputs
   logic [8:0]      core_n_q;
   logic            start_q;
   logic            out_valid_q;
   logic [8:0]      out_dp_q;
   logic [7:0]      out_sr_q;

   logic            slot_free;
   logic            done_hit;
   logic            capture;

`ifdef MAP9_SEQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]   tcnt;
   logic            waiting;
   logic            timed_out;
   logic            out_err_q;
   logic            cap_err;
`endif

   assign in_ready = (count != CW'(DEPTH));
   assign push     = bus.in_valid && in_ready;
   assign pop      = (state == S_IDLE) && (count != '0);

   always_comb begin
      slot_free = !out_valid_q || bus.out_ready;
      done_hit  = (state == S_WAIT_DONE) && bus.core_done;
`ifdef MAP9_SEQ_TIMEOUT_EN
      waiting   = (state == S_WAIT_CLR) || (state == S_WAIT_DONE);
      // Fires on the wait cycle whose increment would bring the count to TIMEOUT.
      timed_out = waiting && (tcnt == TW'(TIMEOUT - 1));
      capture   = slot_free && (done_hit || timed_out);
      cap_err   = !done_hit;
`else
      capture   = slot_free && done_hit;
`endif
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         core_n_q    <= '0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_dp_q    <= '0;
         out_sr_q    <= '0;
`ifdef MAP9_SEQ_TIMEOUT_EN
         out_err_q   <= 1'b0;
         tcnt        <= '0;
`endif
      end else begin
         start_q <= 1'b0;

         // A capture on the same edge as a consume keeps out_valid high.
         if (capture) begin
            out_valid_q <= 1'b1;
            out_dp_q    <= bus.core_dp;
            out_sr_q    <= bus.core_sr;
`ifdef MAP9_SEQ_TIMEOUT_EN
            out_err_q   <= cap_err;
`endif
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

`ifdef MAP9_SEQ_TIMEOUT_EN
         if (state == S_ISSUE) begin
            tcnt <= '0;
         end else if (waiting && !timed_out) begin
            tcnt <= tcnt + TW'(1);
         end
`endif

         case (state)
            S_IDLE: begin
               if (pop) begin
                  core_n_q <= mem[rd_ptr];
                  start_q  <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
               // done still high here belongs to the previous job
               if (capture) begin
                  state <= S_IDLE;
               end else if (!bus.core_done) begin
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (capture) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.core_N     = core_n_q;
   assign bus.core_start = start_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_dp     = out_dp_q;
   assign bus.out_sr     = out_sr_q;
`ifdef MAP9_SEQ_TIMEOUT_EN
   assign bus.out_err    = out_err_q;
`else
   assign bus.out_err    = 1'b0;
`endif
   assign bus.busy       = (state != S_IDLE) || (count != '0);
   assign bus.fifo_count = count;

endmodule
